// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive FIFO with valid/ready drain, overrun, idle timeout and irq.
// Ports: clk_i/rst_ni (async active-low) clock and reset; enable_i gates capture;
//   flush_i empties the FIFO; rx_data_i/rx_ready_i byte strobe from the receiver;
//   m_data_o/m_valid_o/m_ready_i FWFT output stream; level_o occupancy 0..DEPTH;
//   overrun_o/clr_overrun_i sticky drop flag; timeout_o sticky idle flag; irq_o interrupt.
// Optional: UART_RX_CTRL_WATERMARK_EN adds watermark_i; irq base term becomes level >= watermark.
module uart_rx_ctrl #(
  parameter int DEPTH = 16,
  parameter int CLKFREQ = 50000000,
  parameter int BAUD = 9600,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     flush_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_ready_i,
  output logic [7:0]               m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overrun_o,
  input  logic                     clr_overrun_i,
`ifdef UART_RX_CTRL_WATERMARK_EN
  input  logic [$clog2(DEPTH):0]   watermark_i,
`endif
  output logic                     timeout_o,
  output logic                     irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int TC = TIMEOUT_CHARS * 10 * (CLKFREQ / BAUD);
  localparam int CW = $clog2(TC + 1);
  typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} state_t;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0] level_q, level_d;
  logic overrun_q, overrun_d, irq_q, irq_d;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop, full, wr_en, drop, base;
  assign m_valid_o = level_q != '0;
  assign m_data_o = m_valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;
  assign overrun_o = overrun_q;
  assign timeout_o = state_q == EXPIRED;
  assign irq_o = irq_q;
`ifdef UART_RX_CTRL_WATERMARK_EN
  assign base = (level_q >= watermark_i) & (watermark_i != '0);
`else
  assign base = m_valid_o;
`endif
  always_comb begin
    full = level_q == (AW+1)'(DEPTH);
    push = rx_ready_i & enable_i & ~flush_i;
    pop = m_valid_o & m_ready_i & ~flush_i;
    wr_en = push & (~full | pop);
    drop = push & full & ~pop;
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(pop);
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(wr_en);
    level_d = flush_i ? '0 : level_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    overrun_d = drop | (overrun_q & ~clr_overrun_i);
    irq_d = overrun_q | timeout_o | base;
  end
  // Timeout: any push/pop (including a dropped push) restarts the idle count.
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    if (flush_i || level_d == '0) state_d = IDLE;
    else if (state_q == IDLE || push || pop) state_d = COUNT;
    else if (state_q == COUNT) begin
      if (cnt_q == CW'(TC - 1)) state_d = EXPIRED;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_data_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q <= '0;
      overrun_q <= 1'b0;
      irq_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q <= level_d;
      overrun_q <= overrun_d;
      irq_q <= irq_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed plan plus randomized traffic against a queue-based reference model.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
  localparam int CLKFREQ = 1000;
  localparam int BAUD = 100;
  localparam int TCH = 2;
  localparam int TC = TCH * 10 * (CLKFREQ / BAUD);
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk_i = 0, rst_ni = 0, enable_i = 1, flush_i = 0, rx_ready_i = 0, m_ready_i = 0, clr_overrun_i = 0;
  logic [7:0] rx_data_i = 0;
  logic [7:0] m_data_o;
  logic m_valid_o, overrun_o, timeout_o, irq_o;
  logic [LW-1:0] level_o;
`ifdef UART_RX_CTRL_WATERMARK_EN
  logic [LW-1:0] watermark_i = 0;
`endif
  always #5 clk_i = ~clk_i;
  uart_rx_ctrl #(.DEPTH(DEPTH), .CLKFREQ(CLKFREQ), .BAUD(BAUD), .TIMEOUT_CHARS(TCH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i),
    .rx_data_i(rx_data_i), .rx_ready_i(rx_ready_i), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .level_o(level_o), .overrun_o(overrun_o), .clr_overrun_i(clr_overrun_i),
`ifdef UART_RX_CTRL_WATERMARK_EN
    .watermark_i(watermark_i),
`endif
    .timeout_o(timeout_o), .irq_o(irq_o)
  );
  int checks = 0, errors = 0;
  byte unsigned q[$];
  bit ovr, tmo, irq;
  int idle;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic compare_all();
    check("valid", m_valid_o, q.size() != 0);
    check("data", m_data_o, q.size() != 0 ? q[0] : 0);
    check("level", level_o, q.size());
    check("overrun", overrun_o, ovr);
    check("timeout", timeout_o, tmo);
    check("irq", irq_o, irq);
  endtask
  task automatic model_reset();
    q.delete();
    ovr = 0;
    tmo = 0;
    irq = 0;
    idle = 0;
  endtask
  // Called at a falling edge: check, drive, advance the model, clock once.
  task automatic step(input bit rdy, input byte unsigned d, input bit en, input bit fl, input bit mr, input bit clr);
    bit valid, push, pop, drop, base;
    compare_all();
    rx_ready_i = rdy;
    rx_data_i = d;
    enable_i = en;
    flush_i = fl;
    m_ready_i = mr;
    clr_overrun_i = clr;
    valid = q.size() != 0;
    push = rdy && en && !fl;
    pop = valid && mr && !fl;
`ifdef UART_RX_CTRL_WATERMARK_EN
    base = (q.size() >= int'(watermark_i)) && (watermark_i != 0);
`else
    base = valid;
`endif
    irq = ovr || tmo || base;
    drop = push && q.size() == DEPTH && !pop;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push && !drop) q.push_back(d);
    end
    ovr = drop ? 1'b1 : (clr ? 1'b0 : ovr);
    if (fl || q.size() == 0 || push || pop) begin
      idle = 0;
      tmo = 0;
    end else begin
      idle++;
      if (idle >= TC) tmo = 1;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rx_ready_i = 0;
    flush_i = 0;
    clr_overrun_i = 0;
    m_ready_i = 0;
  endtask
  task automatic pushb(input byte unsigned d);
    step(1, d, 1, 0, 0, 0);
  endtask
  task automatic popb();
    step(0, 0, 1, 0, 1, 0);
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk_i);
    check("rst_level", level_o, 0);
    check("rst_valid", m_valid_o, 0);
    check("rst_data", m_data_o, 0);
    check("rst_irq", irq_o, 0);
    rst_ni = 1;
    @(negedge clk_i);
    pushb(8'hA5);
    check("single_data", m_data_o, 8'hA5);
    check("single_level", level_o, 1);
    popb();
    check("single_pop_level", level_o, 0);
    for (int i = 1; i <= 5; i++) pushb(byte'(i));
    check("fill_level", level_o, 4);
    check("fill_overrun", overrun_o, 1);
    for (int i = 1; i <= 4; i++) begin
      check("fill_read", m_data_o, i);
      popb();
    end
    check("fill_empty", m_valid_o, 0);
    step(0, 0, 1, 0, 0, 1);
    check("clr_overrun", overrun_o, 0);
    for (int i = 0; i < 4; i++) pushb(byte'(8'h21 + i));
    step(1, 8'h77, 1, 0, 1, 0);
    check("pp_full_level", level_o, 4);
    check("pp_full_overrun", overrun_o, 0);
    for (int i = 0; i < 4; i++) begin
      check("pp_read", m_data_o, i == 3 ? 8'h77 : 8'h22 + i);
      popb();
    end
    pushb(8'h10);
    for (int i = 0; i < TC - 1; i++) step(0, 0, 1, 0, 0, 0);
    check("tmo_early", timeout_o, 0);
    step(0, 0, 1, 0, 0, 0);
    check("tmo_fire", timeout_o, 1);
    popb();
    check("tmo_clear", timeout_o, 0);
    check("tmo_empty", level_o, 0);
    for (int i = 0; i < 5; i++) pushb(byte'(8'h30 + i));
    popb();
    popb();
    check("flush_pre_level", level_o, 2);
    step(1, 8'h99, 1, 1, 0, 0);
    check("flush_level", level_o, 0);
    check("flush_overrun", overrun_o, 1);
    step(1, 8'h55, 0, 0, 0, 0);
    check("disabled_level", level_o, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) pushb(byte'(8'h40 + i));
    popb();
    check("rst_pre_level", level_o, 3);
    #2 rst_ni = 0;
    #1;
    check("arst_level", level_o, 0);
    check("arst_valid", m_valid_o, 0);
    check("arst_data", m_data_o, 0);
    check("arst_overrun", overrun_o, 0);
    check("arst_timeout", timeout_o, 0);
    check("arst_irq", irq_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1;
`ifdef UART_RX_CTRL_WATERMARK_EN
    watermark_i = 3;
    for (int i = 0; i < 3; i++) pushb(byte'(8'h50 + i));
    check("wm_level", level_o, 3);
    step(0, 0, 1, 0, 0, 0);
    check("wm_irq", irq_o, 1);
    popb();
    step(0, 0, 1, 0, 0, 0);
    check("wm_irq_off", irq_o, 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      int ph, pr, pm;
      ph = (i / 100) % 3;
      pr = ph == 2 ? 5 : 40;
      pm = ph == 0 ? 20 : (ph == 1 ? 80 : 5);
`ifdef UART_RX_CTRL_WATERMARK_EN
      if (i % 250 == 0) watermark_i = LW'($urandom_range(DEPTH));
`endif
      if (i % 700 == 350) begin
        pushb(byte'($urandom));
        for (int k = 0; k < TC + 10; k++) step(0, 0, 1, 0, 0, 0);
      end
      step($urandom_range(99) < pr, byte'($urandom), $urandom_range(99) < 90,
           $urandom_range(99) < 2, $urandom_range(99) < pm, $urandom_range(99) < 5);
    end
    compare_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
